iommu_irq_ctrl: RTL and testbench
=================================

Name: iommu_irq_ctrl

Overview:
- Interrupt pending and dispatch controller for the IOMMU.
- Latches interrupt events from CQ, FQ, HPM and PQ into the ipsr pending bits, and applies software W1C clears.
- In WSI mode (fctl.wsi=1), drives 16 registered wire-signalled interrupt lines from the pending bits and icvec.
- In MSI mode, arbitrates pending sources round-robin and issues one vector request per new pending event to the MSI write engine over a req/ack handshake.

Parameters:
- N_SRC, 4, number of interrupt sources (0=CQ, 1=FQ, 2=HPM, 3=PQ).
- N_VEC, 16, number of interrupt vectors / WSI wires.
- VEC_W, 4, width of a vector index (log2 N_VEC).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- src_ev_i  in  N_SRC  one-cycle event pulse per source.
- src_ie_i  in  N_SRC  per-source interrupt enable (cie, fie, pmie, pie).
- ipsr_clr_i  in  N_SRC  W1C pulse from register file, per source.
- ivec_i  in  N_SRC*VEC_W  icvec; source s vector at bits [s*VEC_W +: VEC_W].
- wsi_en_i  in  1  fctl.wsi.
- ipsr_o  out  N_SRC  pending bits (cip, fip, pmip, pip).
- wsi_wires_o  out  N_VEC  WSI lines, registered.
- msi_req_o  out  1  MSI request valid.
- msi_vec_o  out  VEC_W  vector of the current request.
- msi_src_o  out  N_SRC  one-hot source of the current request.
- msi_ack_i  in  1  MSI engine accepted/completed the request.
- msi_busy_o  out  1  FSM in REQ state.

Behaviour:
- Reset: all outputs and internal state are 0. The round-robin pointer resets to source 0. Reset mid-request drops the request with no ack needed.
- Pending logic:
  - ipsr_d[s] = (ipsr_q[s] & ~ipsr_clr_i[s]) | (src_ev_i[s] & src_ie_i[s]).
  - When a clear and an event coincide, the set wins.
  - Latency: event at cycle N gives ipsr_o at N+1.
- WSI wires:
  - wsi_wires_o[v] is registered: OR over s of (ipsr_q[s] & ivec[s]==v), gated by wsi_en_i. It is 0 when wsi_en_i=0.
  - Latency: event at N gives the wire high at N+2.
  - Multiple sources sharing a vector are ORed.
  - A wire drops one cycle after the ipsr bit clears.
- MSI need flags:
  - need_q[s] sets when ipsr_d[s] & ~ipsr_q[s] & ~wsi_en_i, i.e. on a rising pending edge only.
  - Repeat events while already pending do not re-send.
  - need_q[s] clears on an ack for s, or when ipsr_q[s] clears.
  - Switching wsi_en_i 1->0 does not generate MSIs for bits already pending.
  - Switching 0->1 clears all need flags; an in-flight request still completes.
- FSM IDLE:
  - If any need_q is set, grant the first set source at or after rr_ptr (wrapping N_SRC-1 -> 0).
  - Latch the source and ivec[src]; go to REQ next cycle.
  - An event at N gives msi_req_o at N+2.
- FSM REQ:
  - msi_req_o=1; msi_vec_o and msi_src_o stay stable until ack, and the request is never retracted.
  - On msi_ack_i: clear need for the source, set rr_ptr = src+1 (mod N_SRC), and return to IDLE. msi_req_o deasserts the next cycle.
  - There is at most one request in flight and no back-to-back grant in the ack cycle, giving a minimum 2-cycle spacing.
  - A W1C of the granted source during REQ does not abort the request. need is cleared and no re-send follows.
  - The vector is sampled at grant; later icvec writes do not affect the in-flight request.
- msi_ack_i while in IDLE is ignored.
- msi_vec_o and msi_src_o read 0 while in IDLE.

Test Plan:
- Reset/WSI: reset, wsi_en_i=1, ivec CQ=3, src_ie_i=4'b0001, src_ev_i[0] pulse at N -> ipsr_o=0001 at N+1, wsi_wires_o=0x0008 at N+2; ipsr_clr_i[0] at M -> wires=0 at M+2.
- Shared vector: wsi_en_i=1, CQ and FQ vec=5, both events, then clear CQ only -> wsi_wires_o[5] stays 1 until FQ is cleared; disabled IE -> no pending.
- Set/clear collision: src_ev_i[1] and ipsr_clr_i[1] in the same cycle with fip=1 -> ipsr_o[1] stays 1.
- MSI round-robin: wsi_en_i=0, vectors CQ=1, FQ=2, HPM=7, PQ=9; all four events in the same cycle; ack each request 3 cycles after req -> request order CQ(1), FQ(2), HPM(7), PQ(9), vec/src stable while req is high.
- Re-event/no resend: FQ pending, MSI acked, second FQ event without clear -> no request; clear then event -> one new request.
- Mid-op: W1C of the granted source and icvec write during REQ -> req held with the original vec, completes on ack, no resend; rst_ni low during REQ -> msi_req_o=0 asynchronously, all state 0.

Source files
------------

// File: rtl/iommu_irq_ctrl.sv
// IOMMU interrupt pending/dispatch controller: latches CQ/FQ/HPM/PQ events into ipsr,
// drives registered WSI wires, or issues round-robin MSI vector requests over req/ack.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | no request in flight; grant the next need flag at/after rr_q
//   ST_REQ  | request held stable on msi_*_o until msi_ack_i
module iommu_irq_ctrl #(
  parameter int N_SRC = 4,
  parameter int N_VEC = 16,
  parameter int VEC_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_SRC-1:0]       src_ev_i,
  input  logic [N_SRC-1:0]       src_ie_i,
  input  logic [N_SRC-1:0]       ipsr_clr_i,
  input  logic [N_SRC*VEC_W-1:0] ivec_i,
  input  logic                   wsi_en_i,
  output logic [N_SRC-1:0]       ipsr_o,
  output logic [N_VEC-1:0]       wsi_wires_o,
  output logic                   msi_req_o,
  output logic [VEC_W-1:0]       msi_vec_o,
  output logic [N_SRC-1:0]       msi_src_o,
  input  logic                   msi_ack_i,
  output logic                   msi_busy_o
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] ipsr_q, ipsr_d;
  logic [N_SRC-1:0] need_q, need_d;
  logic [N_SRC-1:0] rise, ack_oh;
  logic [N_VEC-1:0] wsi_q, wsi_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [PTR_W-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] pick;
  logic             pick_vld;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             ack_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ipsr_q  <= '0;
      need_q  <= '0;
      wsi_q   <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      ipsr_q  <= ipsr_d;
      need_q  <= need_d;
      wsi_q   <= wsi_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      vec_q   <= vec_d;
    end
  end

  // Set wins over a coincident W1C.
  assign ipsr_d = (ipsr_q & ~ipsr_clr_i) | (src_ev_i & src_ie_i);
  assign rise   = ipsr_d & ~ipsr_q;

  always_comb begin
    wsi_d = '0;
    for (int s = 0; s < N_SRC; s++) begin
      if (ipsr_q[s]) wsi_d[ivec_i[s*VEC_W +: VEC_W]] = 1'b1;
    end
    if (!wsi_en_i) wsi_d = '0;
  end

  // Descending scan so the smallest offset from rr_q is the last (winning) write.
  always_comb begin
    int j;
    logic [PTR_W-1:0] idx;
    pick     = '0;
    pick_vld = 1'b0;
    j        = 0;
    idx      = '0;
    for (int i = N_SRC-1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      if (j >= N_SRC) j = j - N_SRC;
      idx = PTR_W'(j);
      if (need_q[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    vec_d   = vec_q;
    rr_d    = rr_q;
    ack_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_REQ;
          gnt_d   = pick;
          vec_d   = ivec_i[pick*VEC_W +: VEC_W];
        end
      end
      ST_REQ: begin
        if (msi_ack_i) begin
          ack_hit = 1'b1;
          state_d = ST_IDLE;
          rr_d    = (gnt_q == PTR_W'(N_SRC-1)) ? '0 : gnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // WSI mode owns the interrupts: no new need flags, and existing ones are dropped.
  assign ack_oh = ack_hit ? (N_SRC'(1) << gnt_q) : '0;
  assign need_d = wsi_en_i ? '0 : (rise | (need_q & ipsr_d & ~ack_oh));

  assign ipsr_o      = ipsr_q;
  assign wsi_wires_o = wsi_q;
  assign msi_busy_o  = (state_q == ST_REQ);
  assign msi_req_o   = msi_busy_o;
  assign msi_vec_o   = msi_busy_o ? vec_q : '0;
  assign msi_src_o   = msi_busy_o ? (N_SRC'(1) << gnt_q) : '0;

endmodule

// File: tb/tb_iommu_irq_ctrl.sv
// Directed bench for iommu_irq_ctrl: pending/W1C, WSI wires, MSI round-robin and mid-op cases.
module tb_iommu_irq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  src_ev_i = '0;
  logic [3:0]  src_ie_i = '0;
  logic [3:0]  ipsr_clr_i = '0;
  logic [15:0] ivec_i = '0;
  logic        wsi_en_i = 1'b0;
  logic [3:0]  ipsr_o;
  logic [15:0] wsi_wires_o;
  logic        msi_req_o;
  logic [3:0]  msi_vec_o;
  logic [3:0]  msi_src_o;
  logic        msi_ack_i = 1'b0;
  logic        msi_busy_o;

  int n_vec = 0;
  int n_err = 0;

  iommu_irq_ctrl #(.N_SRC(4), .N_VEC(16), .VEC_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .src_ev_i(src_ev_i), .src_ie_i(src_ie_i),
    .ipsr_clr_i(ipsr_clr_i), .ivec_i(ivec_i), .wsi_en_i(wsi_en_i), .ipsr_o(ipsr_o),
    .wsi_wires_o(wsi_wires_o), .msi_req_o(msi_req_o), .msi_vec_o(msi_vec_o),
    .msi_src_o(msi_src_o), .msi_ack_i(msi_ack_i), .msi_busy_o(msi_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick(); tick();
    n_vec++; if (ipsr_o !== 4'b0) begin n_err++; $display("FAIL reset_ipsr: got %b want 0000", ipsr_o); end
    n_vec++; if (wsi_wires_o !== 16'h0) begin n_err++; $display("FAIL reset_wires: got %h want 0000", wsi_wires_o); end
    n_vec++; if ({msi_req_o, msi_busy_o, msi_vec_o, msi_src_o} !== 10'b0) begin n_err++; $display("FAIL reset_msi: got req=%b busy=%b vec=%h src=%b want all 0", msi_req_o, msi_busy_o, msi_vec_o, msi_src_o); end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_wsi_basic();
    wsi_en_i = 1'b1; ivec_i = 16'h0003; src_ie_i = 4'b0001;
    src_ev_i = 4'b0001; tick(); src_ev_i = 4'b0000;
    n_vec++; if (ipsr_o !== 4'b0001) begin n_err++; $display("FAIL wsi_ipsr_n1: got %b want 0001", ipsr_o); end
    n_vec++; if (wsi_wires_o !== 16'h0000) begin n_err++; $display("FAIL wsi_wire_n1: got %h want 0000", wsi_wires_o); end
    tick();
    n_vec++; if (wsi_wires_o !== 16'h0008) begin n_err++; $display("FAIL wsi_wire_n2: got %h want 0008", wsi_wires_o); end
    n_vec++; if (msi_req_o !== 1'b0) begin n_err++; $display("FAIL wsi_no_msi: got %b want 0", msi_req_o); end
    ipsr_clr_i = 4'b0001; tick(); ipsr_clr_i = 4'b0000;
    n_vec++; if (ipsr_o !== 4'b0000) begin n_err++; $display("FAIL wsi_clr_ipsr: got %b want 0000", ipsr_o); end
    n_vec++; if (wsi_wires_o !== 16'h0008) begin n_err++; $display("FAIL wsi_clr_m1: got %h want 0008", wsi_wires_o); end
    tick();
    n_vec++; if (wsi_wires_o !== 16'h0000) begin n_err++; $display("FAIL wsi_clr_m2: got %h want 0000", wsi_wires_o); end
  endtask

  task automatic test_shared_vec();
    ivec_i = 16'h0055; src_ie_i = 4'b0011;
    src_ev_i = 4'b0011; tick(); src_ev_i = 4'b0000;
    n_vec++; if (ipsr_o !== 4'b0011) begin n_err++; $display("FAIL shared_ipsr: got %b want 0011", ipsr_o); end
    tick();
    n_vec++; if (wsi_wires_o !== 16'h0020) begin n_err++; $display("FAIL shared_wire_on: got %h want 0020", wsi_wires_o); end
    ipsr_clr_i = 4'b0001; tick(); ipsr_clr_i = 4'b0000; tick();
    n_vec++; if (wsi_wires_o !== 16'h0020) begin n_err++; $display("FAIL shared_wire_hold: got %h want 0020", wsi_wires_o); end
    ipsr_clr_i = 4'b0010; tick(); ipsr_clr_i = 4'b0000; tick();
    n_vec++; if (wsi_wires_o !== 16'h0000) begin n_err++; $display("FAIL shared_wire_off: got %h want 0000", wsi_wires_o); end
    src_ev_i = 4'b0100; tick(); src_ev_i = 4'b0000;
    n_vec++; if (ipsr_o !== 4'b0000) begin n_err++; $display("FAIL ie_disabled: got %b want 0000", ipsr_o); end
  endtask

  task automatic test_collision();
    src_ie_i = 4'b0010;
    src_ev_i = 4'b0010; tick(); src_ev_i = 4'b0000;
    n_vec++; if (ipsr_o !== 4'b0010) begin n_err++; $display("FAIL coll_pre: got %b want 0010", ipsr_o); end
    src_ev_i = 4'b0010; ipsr_clr_i = 4'b0010; tick(); src_ev_i = 4'b0000; ipsr_clr_i = 4'b0000;
    n_vec++; if (ipsr_o !== 4'b0010) begin n_err++; $display("FAIL coll_set_wins: got %b want 0010", ipsr_o); end
    ipsr_clr_i = 4'b0010; tick(); ipsr_clr_i = 4'b0000;
    n_vec++; if (ipsr_o !== 4'b0000) begin n_err++; $display("FAIL coll_clr: got %b want 0000", ipsr_o); end
  endtask

  task automatic test_msi_rr();
    logic [3:0] exp_vec [4];
    logic [3:0] exp_src [4];
    int w;
    exp_vec[0] = 4'h1; exp_vec[1] = 4'h2; exp_vec[2] = 4'h7; exp_vec[3] = 4'h9;
    exp_src[0] = 4'b0001; exp_src[1] = 4'b0010; exp_src[2] = 4'b0100; exp_src[3] = 4'b1000;
    ivec_i = 16'h9721; src_ie_i = 4'b1111;
    // Bit already pending in WSI mode must not turn into an MSI after switching modes.
    src_ev_i = 4'b0100; tick(); src_ev_i = 4'b0000;
    wsi_en_i = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (msi_req_o !== 1'b0) begin n_err++; $display("FAIL wsi_to_msi_no_send: got %b want 0", msi_req_o); end
    ipsr_clr_i = 4'b0100; tick(); ipsr_clr_i = 4'b0000;
    src_ev_i = 4'b1111; tick(); src_ev_i = 4'b0000;
    n_vec++; if (msi_req_o !== 1'b0) begin n_err++; $display("FAIL rr_req_n1: got %b want 0", msi_req_o); end
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (msi_req_o !== 1'b1 && w < 6) begin tick(); w++; end
      n_vec++; if (msi_req_o !== 1'b1) begin n_err++; $display("FAIL rr_req_%0d: got %b want 1 (timeout)", k, msi_req_o); end
      n_vec++; if (msi_vec_o !== exp_vec[k] || msi_src_o !== exp_src[k] || msi_busy_o !== 1'b1) begin n_err++; $display("FAIL rr_grant_%0d: got vec=%h src=%b busy=%b want vec=%h src=%b busy=1", k, msi_vec_o, msi_src_o, msi_busy_o, exp_vec[k], exp_src[k]); end
      for (int c = 0; c < 2; c++) begin
        tick();
        n_vec++; if (msi_req_o !== 1'b1 || msi_vec_o !== exp_vec[k] || msi_src_o !== exp_src[k]) begin n_err++; $display("FAIL rr_stable_%0d_%0d: got req=%b vec=%h src=%b want req=1 vec=%h src=%b", k, c, msi_req_o, msi_vec_o, msi_src_o, exp_vec[k], exp_src[k]); end
      end
      tick();
      msi_ack_i = 1'b1; tick(); msi_ack_i = 1'b0;
      n_vec++; if (msi_req_o !== 1'b0 || msi_vec_o !== 4'h0 || msi_src_o !== 4'b0) begin n_err++; $display("FAIL rr_idle_gap_%0d: got req=%b vec=%h src=%b want 0/0/0", k, msi_req_o, msi_vec_o, msi_src_o); end
    end
    tick(); tick();
    n_vec++; if (msi_req_o !== 1'b0) begin n_err++; $display("FAIL rr_done: got %b want 0", msi_req_o); end
    n_vec++; if (ipsr_o !== 4'b1111) begin n_err++; $display("FAIL rr_ipsr_kept: got %b want 1111", ipsr_o); end
    ipsr_clr_i = 4'b1111; tick(); ipsr_clr_i = 4'b0000;
  endtask

  task automatic test_resend();
    int w;
    src_ev_i = 4'b0010; tick(); src_ev_i = 4'b0000;
    w = 0;
    while (msi_req_o !== 1'b1 && w < 6) begin tick(); w++; end
    n_vec++; if (msi_req_o !== 1'b1 || msi_src_o !== 4'b0010 || msi_vec_o !== 4'h2) begin n_err++; $display("FAIL resend_first: got req=%b src=%b vec=%h want 1/0010/2", msi_req_o, msi_src_o, msi_vec_o); end
    msi_ack_i = 1'b1; tick(); msi_ack_i = 1'b0;
    src_ev_i = 4'b0010; tick(); src_ev_i = 4'b0000;
    // Stray ack in IDLE must have no effect.
    msi_ack_i = 1'b1; tick(); msi_ack_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_vec++; if (msi_req_o !== 1'b0) begin n_err++; $display("FAIL resend_none_%0d: got %b want 0", c, msi_req_o); end
      tick();
    end
    ipsr_clr_i = 4'b0010; tick(); ipsr_clr_i = 4'b0000;
    src_ev_i = 4'b0010; tick(); src_ev_i = 4'b0000;
    w = 0;
    while (msi_req_o !== 1'b1 && w < 6) begin tick(); w++; end
    n_vec++; if (msi_req_o !== 1'b1 || msi_src_o !== 4'b0010) begin n_err++; $display("FAIL resend_second: got req=%b src=%b want 1/0010", msi_req_o, msi_src_o); end
    msi_ack_i = 1'b1; tick(); msi_ack_i = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (msi_req_o !== 1'b0) begin n_err++; $display("FAIL resend_once: got %b want 0", msi_req_o); end
    ipsr_clr_i = 4'b0010; tick(); ipsr_clr_i = 4'b0000;
  endtask

  task automatic test_midop();
    int w;
    src_ev_i = 4'b0001; tick(); src_ev_i = 4'b0000;
    w = 0;
    while (msi_req_o !== 1'b1 && w < 6) begin tick(); w++; end
    n_vec++; if (msi_req_o !== 1'b1 || msi_vec_o !== 4'h1) begin n_err++; $display("FAIL midop_req: got req=%b vec=%h want 1/1", msi_req_o, msi_vec_o); end
    ipsr_clr_i = 4'b0001; ivec_i = 16'h972c; tick(); ipsr_clr_i = 4'b0000;
    n_vec++; if (msi_req_o !== 1'b1 || msi_vec_o !== 4'h1 || msi_src_o !== 4'b0001) begin n_err++; $display("FAIL midop_hold: got req=%b vec=%h src=%b want 1/1/0001", msi_req_o, msi_vec_o, msi_src_o); end
    n_vec++; if (ipsr_o !== 4'b0000) begin n_err++; $display("FAIL midop_ipsr: got %b want 0000", ipsr_o); end
    msi_ack_i = 1'b1; tick(); msi_ack_i = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (msi_req_o !== 1'b0) begin n_err++; $display("FAIL midop_no_resend: got %b want 0", msi_req_o); end
    ivec_i = 16'h9721;
    src_ev_i = 4'b0100; tick(); src_ev_i = 4'b0000;
    w = 0;
    while (msi_req_o !== 1'b1 && w < 6) begin tick(); w++; end
    n_vec++; if (msi_req_o !== 1'b1 || msi_vec_o !== 4'h7) begin n_err++; $display("FAIL midop_hpm_req: got req=%b vec=%h want 1/7", msi_req_o, msi_vec_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_vec++; if ({msi_req_o, msi_busy_o, msi_vec_o, msi_src_o} !== 10'b0) begin n_err++; $display("FAIL async_rst_msi: got req=%b busy=%b vec=%h src=%b want all 0", msi_req_o, msi_busy_o, msi_vec_o, msi_src_o); end
    n_vec++; if (ipsr_o !== 4'b0000 || wsi_wires_o !== 16'h0) begin n_err++; $display("FAIL async_rst_state: got ipsr=%b wires=%h want 0/0", ipsr_o, wsi_wires_o); end
    tick();
    rst_ni = 1'b1;
    tick();
    // Pointer was 1 before reset; after reset CQ must win over PQ.
    src_ev_i = 4'b1001; tick(); src_ev_i = 4'b0000;
    w = 0;
    while (msi_req_o !== 1'b1 && w < 6) begin tick(); w++; end
    n_vec++; if (msi_req_o !== 1'b1 || msi_src_o !== 4'b0001 || msi_vec_o !== 4'h1) begin n_err++; $display("FAIL rst_rr_ptr: got req=%b src=%b vec=%h want 1/0001/1", msi_req_o, msi_src_o, msi_vec_o); end
    msi_ack_i = 1'b1; tick(); msi_ack_i = 1'b0;
    w = 0;
    while (msi_req_o !== 1'b1 && w < 6) begin tick(); w++; end
    n_vec++; if (msi_req_o !== 1'b1 || msi_src_o !== 4'b1000 || msi_vec_o !== 4'h9) begin n_err++; $display("FAIL rst_rr_next: got req=%b src=%b vec=%h want 1/1000/9", msi_req_o, msi_src_o, msi_vec_o); end
    msi_ack_i = 1'b1; tick(); msi_ack_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wsi_basic();
    test_shared_vec();
    test_collision();
    test_msi_rr();
    test_resend();
    test_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
